rr_tag_arbiter: RTL and testbench
=================================

# rr_tag_arbiter

Return-path merge block for the packet-routing interconnect: collects 32-bit response words from up to 16 addressable modules over val/rdy, selects one per cycle by round-robin, prepends the source index as an address tag and presents the tagged packet to the SPI minion adapter's receive side. It mirrors the router, which strips the address and fans packets out. Tagged packets are `{addr, data}` with `addr` in the MSBs. A one-entry output register keeps every path into the SPI adapter registered.

## Interface
- `nbits`, 32, data width of each module response
- `num_inputs`, 16, number of source ports (2..16, need not be a power of two)
- `addr_bits`, `$clog2(num_inputs)` (derived, local), width of the address tag
- `clk`  in  1  single clock; all state on rising edge
- `reset`  in  1  asynchronous, active-low; asserting (0) clears all state immediately
- `recv_val[num_inputs]`  in  1 each  source i has a word
- `recv_rdy[num_inputs]`  out  1 each  source i's word is taken this cycle
- `recv_msg[num_inputs]`  in  nbits each  source i data
- `send_val`  out  1  tagged packet valid
- `send_rdy`  in  1  SPI adapter accepts
- `send_msg`  out  addr_bits+nbits  `{index[addr_bits-1:0], data}`

## Operation
- Output register states: EMPTY, FULL.
- `can_load = EMPTY || (send_val && send_rdy)`.
- Grant: first i with `recv_val[i]` searching circularly from `ptr` (ptr, ptr+1, …, wrapping at num_inputs-1 → 0). At most one grant per cycle.
- `recv_rdy[i] = can_load && grant[i]`; every other source has rdy low.
- On transfer (`recv_val[g] && recv_rdy[g]`):
  - load `{g, recv_msg[g]}`; state → FULL;
  - `ptr ← (g == num_inputs-1) ? 0 : g+1`.
- FULL with `send_rdy` and no grant → EMPTY.
- FULL without `send_rdy`: hold register, ptr and all outputs stable; all recv_rdy low.
- No input valid: ptr unchanged, no rdy asserted.
- Simultaneous drain and load: new packet replaces old in the same edge; no bubble.
- Fairness: a continuously valid source is served within num_inputs transfers.
- Tag width: index truncated to addr_bits. Indices ≥ num_inputs never occur.
- Data passes unmodified.

## Timing
- Reset values (asynchronous): state EMPTY, `send_val=0`, `send_msg=0`, `ptr=0`, all `recv_rdy=0`.
- Reset asserted mid-packet: any held packet is discarded, not replayed.
- Latency: a word accepted at edge N appears on `send_msg` with `send_val=1` from edge N onward, i.e. one register stage.
- Throughput: one packet per cycle while `send_rdy` stays high.
- `send_val` is register-driven and never depends combinationally on `send_rdy` or `recv_*`.
- `recv_rdy` is combinational from `recv_val`, `ptr`, state and `send_rdy`.
- Sources must not make `recv_val` depend on `recv_rdy`.

## Structure
- Shared interconnect package holds:
  - `MAX_ADDRESSABLE_SRCS_POW_2 = 16` and its log2;
  - the tagged-packet typedef `{addr, data}`, which is common with the router and SPI adapter.
- Sub-module `rr_grant_picker`: combinational; inputs are the `num_inputs` valid vector and `ptr`. It outputs a one-hot grant, the encoded index and `any_valid`. Implement it as a doubled-vector priority search.
- Top level holds the output register, state bit, ptr and the rdy gating.

## Test plan
- Reset then idle, all val low: `send_val=0`, `send_msg=0`, all rdy low for 10 cycles.
- Single source: input 5 sends 0x0000_ABCD with send_rdy=1. Next cycle `send_msg=0x5_0000ABCD`, then ptr=6.
- All 16 valid continuously, each with data equal to its index, send_rdy=1. Tags emitted 0,1,…,15,0,… with one packet per cycle and no repeats before wrap.
- Backpressure:
  - inputs 3 and 9 valid, send_rdy=0 for 4 cycles after the first load: `send_msg` holds `0x3_…` and all rdy stay low;
  - then send_rdy=1: `0x9_…` follows on the next cycle with no bubble.
- Non-power-of-two, num_inputs=5 (addr_bits=3): inputs 4 and 0 valid. Grants go 0, then 4, then 0, with ptr wrapping from 4 to 0.
- Reset pulse while FULL with send_rdy=0: `send_val` drops asynchronously. After release the old packet is not re-sent and ptr=0.

Source files
------------

// File: rtl/rr_tag_arbiter_pkg.sv
// Shared interconnect definitions for the return-path merge block.
// Holds the addressable-source limits, the tagged-packet layout that the
// router and the SPI minion adapter also use, and the output register's
// state encoding.
package rr_tag_arbiter_pkg;

    localparam int MAX_ADDRESSABLE_SRCS_POW_2 = 16;
    localparam int MAX_ADDR_BITS              = $clog2(MAX_ADDRESSABLE_SRCS_POW_2);
    localparam int PKT_DATA_BITS              = 32;

    // Tag sits in the MSBs so that the router can strip it with a plain slice.
    typedef struct packed {
        logic [MAX_ADDR_BITS-1:0] addr;
        logic [PKT_DATA_BITS-1:0] data;
    } tagged_pkt_t;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_t;

endpackage

// File: rtl/rr_grant_picker.sv
// Combinational round-robin picker.
// Ports:
//   val       in   one valid bit per source
//   ptr       in   index of the highest-priority source this cycle
//   grant     out  one-hot grant (all zero when nothing is valid)
//   index     out  encoded index of the granted source
//   any_valid out  at least one source is valid
module rr_grant_picker
    import rr_tag_arbiter_pkg::*;
#(
    parameter  int num_inputs = 16,
    localparam int addr_bits  = $clog2(num_inputs)
) (
    input  logic [num_inputs-1:0] val,
    input  logic [addr_bits-1:0]  ptr,
    output logic [num_inputs-1:0] grant,
    output logic [addr_bits-1:0]  index,
    output logic                  any_valid
);

    logic [num_inputs-1:0]   hi_mask;
    logic [2*num_inputs-1:0] dbl;
    int                      pos;

    // The lower half keeps only sources at or above ptr and the upper half is
    // the full vector, so the lowest set bit of the doubled vector is the
    // first valid source found walking circularly from ptr.
    always_comb begin
        for (int i = 0; i < num_inputs; i++) begin
            hi_mask[i] = (i >= int'(ptr));
        end
        dbl = {val, val & hi_mask};
        pos = 0;
        for (int k = 2*num_inputs-1; k >= 0; k--) begin
            if (dbl[k]) begin
                pos = k;
            end
        end
        any_valid = |val;
        index     = addr_bits'((pos >= num_inputs) ? (pos - num_inputs) : pos);
        grant     = '0;
        if (any_valid) begin
            grant[index] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_tag_arbiter.sv
// Return-path merge: round-robin selects one source word per cycle, prepends
// the source index as an address tag and holds it in a one-entry output
// register towards the SPI minion adapter.
// Ports:
//   clk       in   clock, rising edge
//   reset     in   asynchronous active-low reset
//   recv_val  in   per-source valid
//   recv_rdy  out  per-source ready (word taken this cycle)
//   recv_msg  in   per-source data words
//   send_val  out  tagged packet valid (register driven)
//   send_rdy  in   downstream accepts
//   send_msg  out  {index, data}
//
// state     | meaning
// ----------+--------------------------------------------------
// OUT_EMPTY | output register holds nothing, any grant may load
// OUT_FULL  | packet presented; reload only when it drains
module rr_tag_arbiter
    import rr_tag_arbiter_pkg::*;
#(
    parameter  int nbits      = 32,
    parameter  int num_inputs = 16,
    localparam int addr_bits  = $clog2(num_inputs)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [num_inputs-1:0]      recv_val,
    output logic [num_inputs-1:0]      recv_rdy,
    input  logic [nbits-1:0]           recv_msg [num_inputs],
    output logic                       send_val,
    input  logic                       send_rdy,
    output logic [addr_bits+nbits-1:0] send_msg
);

    out_state_t                 state_q;
    logic [addr_bits-1:0]       ptr_q;
    logic [addr_bits+nbits-1:0] msg_q;

    logic [num_inputs-1:0]      grant;
    logic [addr_bits-1:0]       grant_idx;
    logic                       any_valid;
    logic                       can_load;
    logic                       load;

    rr_grant_picker #(
        .num_inputs (num_inputs)
    ) u_picker (
        .val       (recv_val),
        .ptr       (ptr_q),
        .grant     (grant),
        .index     (grant_idx),
        .any_valid (any_valid)
    );

    assign send_val = (state_q == OUT_FULL);
    assign send_msg = msg_q;

    // When FULL, send_val is 1, so draining reduces to send_rdy.
    assign can_load = (state_q == OUT_EMPTY) || send_rdy;
    assign recv_rdy = can_load ? grant : '0;
    assign load     = can_load && any_valid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= OUT_EMPTY;
            ptr_q   <= '0;
            msg_q   <= '0;
        end else if (load) begin
            msg_q   <= {grant_idx, recv_msg[grant_idx]};
            state_q <= OUT_FULL;
            ptr_q   <= (grant_idx == addr_bits'(num_inputs-1)) ? '0
                                                               : grant_idx + addr_bits'(1);
        end else if (send_rdy) begin
            state_q <= OUT_EMPTY;
        end
    end

endmodule

// File: tb/tb_rr_tag_arbiter.sv
module tb_rr_tag_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b1;

    logic [15:0] val16 = '0;
    logic [15:0] rdy16;
    logic [31:0] msg16 [16];
    logic        send_val16;
    logic        send_rdy16 = 1'b0;
    logic [35:0] send_msg16;

    logic [4:0]  val5 = '0;
    logic [4:0]  rdy5;
    logic [31:0] msg5 [5];
    logic        send_val5;
    logic        send_rdy5 = 1'b0;
    logic [34:0] send_msg5;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model of the 16-input instance
    int          m_ptr;
    bit          m_full;
    logic [35:0] m_msg;
    logic [15:0] exp_rdy;
    int          exp_g;

    rr_tag_arbiter #(.nbits(32), .num_inputs(16)) u_dut16 (
        .clk      (clk),
        .reset    (rst_n),
        .recv_val (val16),
        .recv_rdy (rdy16),
        .recv_msg (msg16),
        .send_val (send_val16),
        .send_rdy (send_rdy16),
        .send_msg (send_msg16)
    );

    rr_tag_arbiter #(.nbits(32), .num_inputs(5)) u_dut5 (
        .clk      (clk),
        .reset    (rst_n),
        .recv_val (val5),
        .recv_rdy (rdy5),
        .recv_msg (msg5),
        .send_val (send_val5),
        .send_rdy (send_rdy5),
        .send_msg (send_msg5)
    );

    // First valid source walking circularly from p, or -1 if none.
    function automatic int rr_pick(input logic [15:0] v, input int p);
        for (int k = 0; k < 16; k++) begin
            int i = (p + k) % 16;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_comb();
        bit can;
        #1;
        can     = !m_full || send_rdy16;
        exp_g   = rr_pick(val16, m_ptr);
        exp_rdy = (can && exp_g >= 0) ? (16'd1 << exp_g) : 16'd0;
    endtask

    task automatic clock_edge();
        if (exp_rdy != 16'd0) begin
            m_full = 1'b1;
            m_msg  = {exp_g[3:0], msg16[exp_g]};
            m_ptr  = (exp_g + 1) % 16;
        end else if (m_full && send_rdy16) begin
            m_full = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        val16      = '0;
        val5       = '0;
        send_rdy16 = 1'b0;
        send_rdy5  = 1'b0;
        @(posedge clk);
        #3;
        rst_n  = 1'b1;
        m_ptr  = 0;
        m_full = 1'b0;
        m_msg  = '0;
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if (send_val5 !== 1'b0 || rdy5 !== 5'd0) begin
            tests_failed++;
            $display("FAIL reset_dut5: send_val=%b rdy=%b expected 0/0", send_val5, rdy5);
        end
        for (int c = 0; c < 10; c++) begin
            model_comb();
            tests_run++;
            if (rdy16 !== 16'h0000) begin
                tests_failed++;
                $display("FAIL reset_idle_rdy: got %h expected 0000", rdy16);
            end
            clock_edge();
            tests_run++;
            if (send_val16 !== 1'b0 || send_msg16 !== 36'h0) begin
                tests_failed++;
                $display("FAIL reset_idle_out: val=%b msg=%h expected 0/0", send_val16, send_msg16);
            end
        end
    endtask

    task automatic test_single();
        val16      = 16'h0020;
        msg16[5]   = 32'h0000_ABCD;
        send_rdy16 = 1'b1;
        model_comb();
        tests_run++;
        if (rdy16 !== 16'h0020) begin
            tests_failed++;
            $display("FAIL single_rdy: got %h expected 0020", rdy16);
        end
        clock_edge();
        tests_run++;
        if (send_val16 !== 1'b1 || send_msg16 !== 36'h5_0000ABCD) begin
            tests_failed++;
            $display("FAIL single_out: val=%b msg=%h expected 1/5_0000abcd", send_val16, send_msg16);
        end
        for (int i = 0; i < 16; i++) msg16[i] = 32'(i);
        val16 = 16'hFFFF;
        model_comb();
        tests_run++;
        if (rdy16 !== 16'h0040) begin
            tests_failed++;
            $display("FAIL single_ptr_next: got %h expected 0040", rdy16);
        end
        clock_edge();
        tests_run++;
        if (send_msg16 !== {4'h6, 32'h6}) begin
            tests_failed++;
            $display("FAIL single_next_out: got %h expected 6_00000006", send_msg16);
        end
        val16 = '0;
        model_comb();
        clock_edge();
        tests_run++;
        if (send_val16 !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_drain: val=%b expected 0", send_val16);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int i = 0; i < 16; i++) msg16[i] = 32'(i);
        val16      = 16'hFFFF;
        send_rdy16 = 1'b1;
        for (int c = 0; c < 34; c++) begin
            model_comb();
            tests_run++;
            if (rdy16 !== (16'd1 << (c % 16))) begin
                tests_failed++;
                $display("FAIL rr_rdy[%0d]: got %h expected %h", c, rdy16, 16'd1 << (c % 16));
            end
            clock_edge();
            tests_run++;
            if (send_val16 !== 1'b1 || send_msg16 !== {4'(c % 16), 32'(c % 16)}) begin
                tests_failed++;
                $display("FAIL rr_out[%0d]: val=%b msg=%h expected 1/%h", c, send_val16,
                         send_msg16, {4'(c % 16), 32'(c % 16)});
            end
        end
        val16 = '0;
        model_comb();
        clock_edge();
    endtask

    task automatic test_backpressure();
        do_reset();
        msg16[3]   = 32'h3333_3333;
        msg16[9]   = 32'h9999_9999;
        val16      = 16'h0208;
        send_rdy16 = 1'b0;
        model_comb();
        tests_run++;
        if (rdy16 !== 16'h0008) begin
            tests_failed++;
            $display("FAIL bp_first_rdy: got %h expected 0008", rdy16);
        end
        clock_edge();
        tests_run++;
        if (send_val16 !== 1'b1 || send_msg16 !== 36'h3_33333333) begin
            tests_failed++;
            $display("FAIL bp_first_out: val=%b msg=%h expected 1/3_33333333", send_val16, send_msg16);
        end
        for (int c = 0; c < 4; c++) begin
            model_comb();
            tests_run++;
            if (rdy16 !== 16'h0000) begin
                tests_failed++;
                $display("FAIL bp_hold_rdy[%0d]: got %h expected 0000", c, rdy16);
            end
            clock_edge();
            tests_run++;
            if (send_val16 !== 1'b1 || send_msg16 !== 36'h3_33333333) begin
                tests_failed++;
                $display("FAIL bp_hold_out[%0d]: val=%b msg=%h expected 1/3_33333333", c,
                         send_val16, send_msg16);
            end
        end
        send_rdy16 = 1'b1;
        model_comb();
        tests_run++;
        if (rdy16 !== 16'h0200) begin
            tests_failed++;
            $display("FAIL bp_release_rdy: got %h expected 0200", rdy16);
        end
        clock_edge();
        tests_run++;
        if (send_val16 !== 1'b1 || send_msg16 !== 36'h9_99999999) begin
            tests_failed++;
            $display("FAIL bp_release_out: val=%b msg=%h expected 1/9_99999999", send_val16, send_msg16);
        end
        val16 = '0;
        model_comb();
        clock_edge();
    endtask

    task automatic test_non_pow2();
        int seq[4] = '{0, 4, 0, 4};
        do_reset();
        for (int i = 0; i < 5; i++) msg5[i] = 32'hA0 + 32'(i);
        val5      = 5'b10001;
        send_rdy5 = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            tests_run++;
            if (rdy5 !== (5'd1 << seq[c])) begin
                tests_failed++;
                $display("FAIL np2_rdy[%0d]: got %b expected %b", c, rdy5, 5'd1 << seq[c]);
            end
            @(posedge clk);
            #1;
            tests_run++;
            if (send_val5 !== 1'b1 || send_msg5 !== {3'(seq[c]), msg5[seq[c]]}) begin
                tests_failed++;
                $display("FAIL np2_out[%0d]: val=%b msg=%h expected 1/%h", c, send_val5,
                         send_msg5, {3'(seq[c]), msg5[seq[c]]});
            end
        end
        val5 = '0;
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        msg16[7]   = 32'hDEAD_BEEF;
        msg16[0]   = 32'h0000_1234;
        val16      = 16'h0080;
        send_rdy16 = 1'b0;
        model_comb();
        clock_edge();
        tests_run++;
        if (send_val16 !== 1'b1 || send_msg16 !== 36'h7_DEADBEEF) begin
            tests_failed++;
            $display("FAIL mid_load: val=%b msg=%h expected 1/7_deadbeef", send_val16, send_msg16);
        end
        val16 = '0;
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (send_val16 !== 1'b0 || send_msg16 !== 36'h0 || rdy16 !== 16'h0) begin
            tests_failed++;
            $display("FAIL mid_async: val=%b msg=%h rdy=%h expected 0/0/0", send_val16, send_msg16, rdy16);
        end
        #2;
        rst_n      = 1'b1;
        m_ptr      = 0;
        m_full     = 1'b0;
        m_msg      = '0;
        send_rdy16 = 1'b1;
        @(posedge clk);
        #1;
        for (int c = 0; c < 3; c++) begin
            model_comb();
            clock_edge();
            tests_run++;
            if (send_val16 !== 1'b0) begin
                tests_failed++;
                $display("FAIL mid_no_replay[%0d]: val=%b expected 0", c, send_val16);
            end
        end
        val16 = 16'hFFFF;
        model_comb();
        tests_run++;
        if (rdy16 !== 16'h0001) begin
            tests_failed++;
            $display("FAIL mid_ptr_zero: got %h expected 0001", rdy16);
        end
        clock_edge();
        tests_run++;
        if (send_msg16 !== 36'h0_00001234) begin
            tests_failed++;
            $display("FAIL mid_after_out: got %h expected 0_00001234", send_msg16);
        end
        val16 = '0;
        model_comb();
        clock_edge();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 500; c++) begin
            case ($urandom_range(0, 3))
                0:       val16 = '0;
                1:       val16 = 16'($urandom);
                default: val16 = 16'($urandom) & 16'($urandom);
            endcase
            for (int i = 0; i < 16; i++) msg16[i] = $urandom;
            send_rdy16 = ($urandom_range(0, 3) != 0);
            model_comb();
            tests_run++;
            if (rdy16 !== exp_rdy) begin
                tests_failed++;
                $display("FAIL rand_rdy[%0d]: got %h expected %h", c, rdy16, exp_rdy);
            end
            clock_edge();
            tests_run++;
            if (send_val16 !== m_full || (m_full && send_msg16 !== m_msg)) begin
                tests_failed++;
                $display("FAIL rand_out[%0d]: val=%b msg=%h expected %b/%h", c, send_val16,
                         send_msg16, m_full, m_msg);
            end
        end
        val16 = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_non_pow2();
        test_reset_mid_packet();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
